// File: rtl/mem_arbiter_pkg.sv
// Shared constants for mem_arbiter: one-hot FSM encodings, port ids, default widths.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // One-hot arbiter states
  localparam int STATE_W = 4;
  localparam logic [STATE_W-1:0] ST_IDLE    = 4'b0001;
  localparam logic [STATE_W-1:0] ST_GRANT_D = 4'b0010;
  localparam logic [STATE_W-1:0] ST_GRANT_I = 4'b0100;
  localparam logic [STATE_W-1:0] ST_RESP    = 4'b1000;

  // Requester ids, as stored in the last-grant register
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, load/store port and memory port.
// master = arbiter view, slave = core/memory environment view.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_W,
  parameter int DATA_WIDTH = DEF_DATA_W
);

  logic                  INSTR_REQ;
  logic [ADDR_WIDTH-1:0] INSTR_ADDR;
  logic                  INSTR_VALID;
  logic [DATA_WIDTH-1:0] INSTR_RDATA;

  logic                  DATA_REQ;
  logic                  DATA_WRITE_ENABLE;
  logic [ADDR_WIDTH-1:0] DATA_ADDR;
  logic [DATA_WIDTH-1:0] DATA_WDATA;
  logic                  DATA_VALID;
  logic [DATA_WIDTH-1:0] DATA_RDATA;

  logic                  MEM_REQ;
  logic                  MEM_WE;
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic [DATA_WIDTH-1:0] MEM_WDATA;
  logic                  MEM_RVALID;
  logic [DATA_WIDTH-1:0] MEM_RDATA;

  modport master (
    input  INSTR_REQ, INSTR_ADDR, DATA_REQ, DATA_WRITE_ENABLE, DATA_ADDR, DATA_WDATA,
           MEM_RVALID, MEM_RDATA,
    output INSTR_VALID, INSTR_RDATA, DATA_VALID, DATA_RDATA,
           MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA
  );

  modport slave (
    output INSTR_REQ, INSTR_ADDR, DATA_REQ, DATA_WRITE_ENABLE, DATA_ADDR, DATA_WDATA,
           MEM_RVALID, MEM_RDATA,
    input  INSTR_VALID, INSTR_RDATA, DATA_VALID, DATA_RDATA,
           MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA
  );

endinterface

// File: rtl/mem_arb_req_latch.sv
// Per-requester capture stage: pending flag plus registered address/WE/WDATA.
// A request is taken only while the port is idle (not pending/granted and not
// returning VALID), so a level REQ held across a transaction counts once.
module mem_arb_req_latch #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          busy,     // port's VALID is high this cycle
  input  logic          clr,      // memory acknowledged this port's access
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  output logic          pending,
  output logic [AW-1:0] addr_q,
  output logic          we_q,
  output logic [DW-1:0] wdata_q
);

  logic          pending_q, pending_d;
  logic [AW-1:0] addr_d;
  logic          we_d;
  logic [DW-1:0] wdata_d;
  logic          capture;

  // Pending is held through the grant and drops on the acknowledge edge
  always_comb begin
    capture   = req & ~pending_q & ~busy;
    pending_d = pending_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    if (clr) begin
      pending_d = 1'b0;
    end else if (capture) begin
      pending_d = 1'b1;
      addr_d    = addr;
      we_d      = we;
      wdata_d   = wdata;
    end
  end

  // Capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-ported memory (fetch vs load/store).
// Optional macro MEMARB_RR_EN: round-robin between ports when both are
// pending; otherwise fixed priority, data before instruction.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_W,
  parameter int DATA_WIDTH = DEF_DATA_W
) (
  input  logic          CLK,
  input  logic          RES_N,
  mem_arbiter_if.master bus
);

  logic [STATE_W-1:0]    state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  data_valid_q, data_valid_d;
  logic [DATA_WIDTH-1:0] instr_rdata_q, instr_rdata_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;

  logic                  i_pend, d_pend;
  logic [ADDR_WIDTH-1:0] i_addr, d_addr;
  logic                  d_we;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  unused_i_we;
  logic [DATA_WIDTH-1:0] unused_i_wdata;

  logic gnt_d, gnt_i, pick_d;

  assign gnt_d = (state_q == ST_GRANT_D);
  assign gnt_i = (state_q == ST_GRANT_I);

  mem_arb_req_latch #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_lat_i (
    .clk     (CLK),
    .rst_n   (RES_N),
    .req     (bus.INSTR_REQ),
    .busy    (instr_valid_q),
    .clr     (gnt_i & bus.MEM_RVALID),
    .addr    (bus.INSTR_ADDR),
    .we      (1'b0),
    .wdata   ({DATA_WIDTH{1'b0}}),
    .pending (i_pend),
    .addr_q  (i_addr),
    .we_q    (unused_i_we),
    .wdata_q (unused_i_wdata)
  );

  mem_arb_req_latch #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_lat_d (
    .clk     (CLK),
    .rst_n   (RES_N),
    .req     (bus.DATA_REQ),
    .busy    (data_valid_q),
    .clr     (gnt_d & bus.MEM_RVALID),
    .addr    (bus.DATA_ADDR),
    .we      (bus.DATA_WRITE_ENABLE),
    .wdata   (bus.DATA_WDATA),
    .pending (d_pend),
    .addr_q  (d_addr),
    .we_q    (d_we),
    .wdata_q (d_wdata)
  );

`ifdef MEMARB_RR_EN
  // Contention goes to whichever port was not served last
  assign pick_d = d_pend & (~i_pend | (last_grant_q != PORT_D));
`else
  // Data always wins; last-grant is tracked but not consulted
  assign pick_d = d_pend;
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  // Arbiter FSM and response registers; acks outside a grant are ignored
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    instr_valid_d = 1'b0;
    data_valid_d  = 1'b0;
    instr_rdata_d = instr_rdata_q;
    data_rdata_d  = data_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_d)      state_d = ST_GRANT_D;
        else if (i_pend) state_d = ST_GRANT_I;
      end
      ST_GRANT_D: begin
        if (bus.MEM_RVALID) begin
          state_d      = ST_RESP;
          data_valid_d = 1'b1;
          last_grant_d = PORT_D;
          if (!d_we) data_rdata_d = bus.MEM_RDATA;
        end
      end
      ST_GRANT_I: begin
        if (bus.MEM_RVALID) begin
          state_d       = ST_RESP;
          instr_valid_d = 1'b1;
          last_grant_d  = PORT_I;
          instr_rdata_d = bus.MEM_RDATA;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= PORT_I;
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      instr_valid_q <= instr_valid_d;
      data_valid_q  <= data_valid_d;
      instr_rdata_q <= instr_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign bus.INSTR_VALID = instr_valid_q;
  assign bus.INSTR_RDATA = instr_rdata_q;
  assign bus.DATA_VALID  = data_valid_q;
  assign bus.DATA_RDATA  = data_rdata_q;

  // Memory side decoded from state so it drops the instant reset asserts
  assign bus.MEM_REQ   = gnt_d | gnt_i;
  assign bus.MEM_WE    = gnt_d & d_we;
  assign bus.MEM_ADDR  = gnt_d ? d_addr : (gnt_i ? i_addr : '0);
  assign bus.MEM_WDATA = gnt_d ? d_wdata : '0;

endmodule
